// File: rtl/display_pkg.sv
// Shared types and segment constants for the two-digit seven-segment display path.
// Segment vectors are ordered {g,f,e,d,c,b,a}, active high.
package display_pkg;

    typedef enum logic [1:0] {
        BLANK_U = 2'd0,
        SHOW_U  = 2'd1,
        BLANK_T = 2'd2,
        SHOW_T  = 2'd3
    } state_t;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_to_segments.sv
// BCD digit to seven-segment pattern, purely combinational (zero latency, no flow control).
// Codes 10..15 show a dash rather than garbage.
module bcd_to_segments
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/display_mux.sv
// Time-multiplexed two-digit display driver; samples commit only at the frame boundary.
// Outputs registered with the state they accompany; load is a strobe and is never stalled.
module display_mux
    import display_pkg::*;
#(
    parameter int REFRESH_CYCLES     = 100,
    parameter int BLANK_CYCLES       = 4,
    parameter bit BLANK_LEADING_ZERO = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] ten_count,
    input  logic [3:0] unit_count,
    output logic [6:0] segments,
    output logic       digit
);

    localparam int MAX_PHASE = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
    localparam int TW        = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;
    localparam logic [TW-1:0] R_LAST = TW'(REFRESH_CYCLES - 1);
    localparam logic [TW-1:0] B_LAST = TW'(BLANK_CYCLES - 1);

    state_t        state;
    state_t        state_nx;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nx;
    logic          phase_end;
    logic          commit;

    logic [3:0] pend_tens, pend_units;
    logic [3:0] disp_tens, disp_units;
    logic [3:0] pend_tens_nx, pend_units_nx;
    logic [3:0] disp_tens_nx, disp_units_nx;

    logic [3:0] dec_in;
    logic [6:0] dec_out;
    logic [6:0] segments_nx;
    logic       digit_nx;

    always_comb begin
        phase_end = 1'b1;
        state_nx  = BLANK_U;
        case (state)
            BLANK_U: begin
                phase_end = (timer == B_LAST);
                state_nx  = phase_end ? SHOW_U : BLANK_U;
            end
            SHOW_U: begin
                phase_end = (timer == R_LAST);
                state_nx  = phase_end ? BLANK_T : SHOW_U;
            end
            BLANK_T: begin
                phase_end = (timer == B_LAST);
                state_nx  = phase_end ? SHOW_T : BLANK_T;
            end
            SHOW_T: begin
                phase_end = (timer == R_LAST);
                state_nx  = phase_end ? BLANK_U : SHOW_T;
            end
            default: begin
                phase_end = 1'b1;
                state_nx  = BLANK_U;
            end
        endcase
    end

    // Every transition (including recovery from a bad encoding) restarts the timer.
    assign timer_nx = (state_nx != state) ? '0 : timer + 1'b1;

    // A load in the commit cycle lands in pending and flows straight through to disp.
    assign commit        = (state == BLANK_U) && phase_end;
    assign pend_tens_nx  = load ? ten_count  : pend_tens;
    assign pend_units_nx = load ? unit_count : pend_units;
    assign disp_tens_nx  = commit ? pend_tens_nx  : disp_tens;
    assign disp_units_nx = commit ? pend_units_nx : disp_units;

    assign dec_in = (state_nx == SHOW_T) ? disp_tens_nx : disp_units_nx;

    bcd_to_segments u_dec (
        .bcd (dec_in),
        .seg (dec_out)
    );

    always_comb begin
        segments_nx = SEG_OFF;
        case (state_nx)
            SHOW_U:  segments_nx = dec_out;
            SHOW_T:  segments_nx = (BLANK_LEADING_ZERO && (disp_tens_nx == 4'd0)) ? SEG_OFF : dec_out;
            default: segments_nx = SEG_OFF;
        endcase
    end

    assign digit_nx = (state_nx == BLANK_T) || (state_nx == SHOW_T);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= BLANK_U;
            timer      <= '0;
            pend_tens  <= 4'd0;
            pend_units <= 4'd0;
            disp_tens  <= 4'd0;
            disp_units <= 4'd0;
            segments   <= SEG_OFF;
            digit      <= 1'b0;
        end else begin
            state      <= state_nx;
            timer      <= timer_nx;
            pend_tens  <= pend_tens_nx;
            pend_units <= pend_units_nx;
            disp_tens  <= disp_tens_nx;
            disp_units <= disp_units_nx;
            segments   <= segments_nx;
            digit      <= digit_nx;
        end
    end

endmodule

// File: tb/tb_display_mux.sv
// Bench for display_mux: frame-position reference model feeds a scoreboard queue,
// a monitor pops one expected entry per clock and compares both parameterisations.
module tb_display_mux;

    localparam int R     = 8;
    localparam int B     = 2;
    localparam int FRAME = 2 * (R + B);

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [3:0] ten_count = 4'd0;
    logic [3:0] unit_count = 4'd0;
    logic [6:0] seg_blz, seg_nblz;
    logic       dig_blz, dig_nblz;

    always #5 clk = ~clk;

    display_mux #(.REFRESH_CYCLES(R), .BLANK_CYCLES(B), .BLANK_LEADING_ZERO(1'b1)) dut_blz (
        .clk(clk), .reset(reset), .load(load), .ten_count(ten_count), .unit_count(unit_count),
        .segments(seg_blz), .digit(dig_blz)
    );

    display_mux #(.REFRESH_CYCLES(R), .BLANK_CYCLES(B), .BLANK_LEADING_ZERO(1'b0)) dut_nblz (
        .clk(clk), .reset(reset), .load(load), .ten_count(ten_count), .unit_count(unit_count),
        .segments(seg_nblz), .digit(dig_nblz)
    );

    typedef struct packed {
        logic [6:0] seg_blz;
        logic [6:0] seg_nblz;
        logic       dig;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    // Reference model: position within the 20-cycle frame plus the latest and shown samples.
    int         pos = 0;
    logic [3:0] pend_t = 4'd0, pend_u = 4'd0, shown_t = 4'd0, shown_u = 4'd0;
    logic [6:0] seg_tab [16];

    initial seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                        7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h (frame pos %0d)", name, $time, act, exp, pos);
        end
    endtask

    task automatic step(input bit rst, input bit ld, input logic [3:0] t, input logic [3:0] u);
        exp_t e;
        @(negedge clk);
        reset      = rst;
        load       = ld;
        ten_count  = t;
        unit_count = u;
        if (rst) begin
            pos = 0;
            pend_t = 4'd0; pend_u = 4'd0; shown_t = 4'd0; shown_u = 4'd0;
        end else begin
            pos = (pos + 1) % FRAME;
            if (ld) begin
                pend_t = t;
                pend_u = u;
            end
            if (pos == B) begin
                shown_t = pend_t;
                shown_u = pend_u;
            end
        end
        e.dig = (pos >= R + B);
        if (pos >= B && pos < B + R) begin
            e.seg_blz  = seg_tab[shown_u];
            e.seg_nblz = seg_tab[shown_u];
        end else if (pos >= 2 * B + R) begin
            e.seg_blz  = (shown_t == 4'd0) ? 7'h00 : seg_tab[shown_t];
            e.seg_nblz = seg_tab[shown_t];
        end else begin
            e.seg_blz  = 7'h00;
            e.seg_nblz = 7'h00;
        end
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    endtask

    task automatic run_to(input int p);
        for (int i = 0; i < FRAME && pos != p; i++) idle(1);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("seg_blz", seg_blz, e.seg_blz);
                check("seg_nblz", seg_nblz, e.seg_nblz);
                check("digit_blz", {6'd0, dig_blz}, {6'd0, e.dig});
                check("digit_nblz", {6'd0, dig_nblz}, {6'd0, e.dig});
            end
        end
    end

    initial begin
        step(1'b1, 1'b0, 4'd0, 4'd0);
        step(1'b1, 1'b1, 4'd9, 4'd9);
        idle(40);

        run_to(B + R + B + 3);
        step(1'b0, 1'b1, 4'd4, 4'd2);
        idle(2 * FRAME);

        run_to(B + 3);
        step(1'b0, 1'b1, 4'd1, 4'd7);
        idle(1);
        step(1'b0, 1'b1, 4'd3, 4'd9);
        idle(2 * FRAME);

        run_to(B - 1);
        step(1'b0, 1'b1, 4'd5, 4'd5);
        idle(12);

        run_to(B + 2);
        step(1'b0, 1'b1, 4'd12, 4'd0);
        idle(FRAME + 5);
        run_to(B + 2);
        step(1'b0, 1'b1, 4'd0, 4'd3);
        idle(2 * FRAME);

        run_to(B + 2);
        step(1'b0, 1'b1, 4'd8, 4'd8);
        idle(FRAME);
        run_to(2 * B + R + 2);
        step(1'b1, 1'b0, 4'd0, 4'd0);
        idle(2 * FRAME);

        for (int i = 0; i < 500; i++)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 5) == 0,
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

        @(posedge clk);
        #3;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
